// File: rtl/arm_controller.sv
// Control unit for the single-cycle ARM-subset core.
// Decodes the instruction combinationally and holds the NZCV flags.
module arm_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic [3:0]  ALUFlags,
  output logic [1:0]  regSrc,
  output logic        regWrite,
  output logic [1:0]  immSrc,
  output logic        ALUSrc,
  output logic [3:0]  ALUControl,
  output logic        memToReg,
  output logic        memWrite,
  output logic        PCSrc,
  output logic [3:0]  flags
);

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;

  logic       reg_write_raw;
  logic       mem_write_raw;
  logic       pc_src_raw;
  logic       flag_w;
  logic       is_arith;
  logic       cond_ex;
  logic       flag_n, flag_z, flag_c, flag_v;
  logic       unused_instr_bits;

  assign cond  = instr[31:28];
  assign op    = instr[27:26];
  assign funct = instr[25:20];
  assign rd    = instr[15:12];
  assign cmd   = instr[24:21];

  // Register-field and offset bits are consumed by the datapath, not here.
  assign unused_instr_bits = ^{instr[19:16], instr[11:0]};

  assign {flag_n, flag_z, flag_c, flag_v} = flags;

  // Main decode: selects, ALU op and ungated enables.
  always_comb begin
    regSrc        = 2'b00;
    immSrc        = 2'b00;
    ALUSrc        = 1'b0;
    ALUControl    = 4'b0000;
    memToReg      = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    pc_src_raw    = 1'b0;
    flag_w        = 1'b0;
    case (op)
      OP_DP: begin
        ALUSrc        = funct[5];
        ALUControl    = cmd;
        flag_w        = funct[0];
        reg_write_raw = !(cmd[3:2] == 2'b10);
      end
      OP_MEM: begin
        ALUSrc     = 1'b1;
        immSrc     = 2'b01;
        ALUControl = instr[23] ? CMD_ADD : CMD_SUB;
        if (funct[0]) begin
          reg_write_raw = 1'b1;
          memToReg      = 1'b1;
        end else begin
          mem_write_raw = 1'b1;
          regSrc[1]     = 1'b1;
        end
      end
      OP_BR: begin
        regSrc[0]  = 1'b1;
        ALUSrc     = 1'b1;
        immSrc     = 2'b10;
        ALUControl = CMD_ADD;
        pc_src_raw = 1'b1;
      end
      default: ;
    endcase
    // Writing R15 redirects the PC.
    if (reg_write_raw && (rd == 4'd15))
      pc_src_raw = 1'b1;
  end

  // Condition evaluation against the registered flags.
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;
      4'b0001: cond_ex = !flag_z;
      4'b0010: cond_ex = flag_c;
      4'b0011: cond_ex = !flag_c;
      4'b0100: cond_ex = flag_n;
      4'b0101: cond_ex = !flag_n;
      4'b0110: cond_ex = flag_v;
      4'b0111: cond_ex = !flag_v;
      4'b1000: cond_ex = flag_c && !flag_z;
      4'b1001: cond_ex = !flag_c || flag_z;
      4'b1010: cond_ex = (flag_n == flag_v);
      4'b1011: cond_ex = (flag_n != flag_v);
      4'b1100: cond_ex = !flag_z && (flag_n == flag_v);
      4'b1101: cond_ex = flag_z || (flag_n != flag_v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // C and V only follow the ALU for arithmetic commands.
  always_comb begin
    is_arith = 1'b0;
    case (cmd)
      4'b0010, 4'b0011, 4'b0100, 4'b0101,
      4'b0110, 4'b0111, 4'b1010, 4'b1011: is_arith = 1'b1;
      default: is_arith = 1'b0;
    endcase
  end

  // Enables are suppressed while reset is held low.
  assign regWrite = reg_write_raw && cond_ex && reset;
  assign memWrite = mem_write_raw && cond_ex && reset;
  assign PCSrc    = pc_src_raw && cond_ex && reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags <= 4'b0000;
    end else if (flag_w && cond_ex) begin
      flags[3:2] <= ALUFlags[3:2];
      if (is_arith)
        flags[1:0] <= ALUFlags[1:0];
    end
  end

endmodule

// File: tb/tb_arm_controller.sv
// Directed self-checking bench for arm_controller.
module tb_arm_controller;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  regSrc;
  logic        regWrite;
  logic [1:0]  immSrc;
  logic        ALUSrc;
  logic [3:0]  ALUControl;
  logic        memToReg;
  logic        memWrite;
  logic        PCSrc;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  arm_controller dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .ALUFlags   (ALUFlags),
    .regSrc     (regSrc),
    .regWrite   (regWrite),
    .immSrc     (immSrc),
    .ALUSrc     (ALUSrc),
    .ALUControl (ALUControl),
    .memToReg   (memToReg),
    .memWrite   (memWrite),
    .PCSrc      (PCSrc),
    .flags      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, leaving a margin before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Apply an instruction and let decode settle.
  task automatic apply(input logic [31:0] i, input logic [3:0] af);
    instr    = i;
    ALUFlags = af;
    #1;
  endtask

  initial begin
    reset    = 1'b0;
    instr    = 32'h0;
    ALUFlags = 4'h0;

    // Reset held low with ADD R0,R0,R1
    apply(32'hE0800001, 4'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_enables", 32'({regWrite, memWrite, PCSrc}), 32'h0);
    chk("rst_aluctl", 32'(ALUControl), 32'h4);
    step();
    chk("rst_flags_edge", 32'(flags), 32'h0);

    // Release; ADD decodes normally
    reset = 1'b1;
    #1;
    chk("add_enables", 32'({regWrite, memWrite, PCSrc}), 32'b100);
    chk("add_alusrc", 32'(ALUSrc), 32'h0);
    chk("add_aluctl", 32'(ALUControl), 32'h4);
    step();
    chk("add_no_flagw", 32'(flags), 32'h0);

    // CMP R0,#0 with ALU flags Z,C
    apply(32'hE3500000, 4'b0110);
    chk("cmp_enables", 32'({regWrite, memWrite, PCSrc}), 32'h0);
    chk("cmp_sel", 32'({ALUSrc, ALUControl}), 32'b1_1010);
    step();
    chk("cmp_flags", 32'(flags), 32'b0110);

    // BEQ taken (Z=1)
    apply(32'h0A000002, 4'h0);
    chk("beq_enables", 32'({regWrite, memWrite, PCSrc}), 32'b001);
    chk("beq_sel", 32'({regSrc, immSrc, ALUSrc, ALUControl}), 32'b01_10_1_0100);
    // BL executes as B
    apply(32'hEB000000, 4'h0);
    chk("bl_enables", 32'({regWrite, memWrite, PCSrc}), 32'b001);
    step();
    chk("br_flags_kept", 32'(flags), 32'b0110);

    // CMP to set flags 0011, then MOVS keeps C,V
    apply(32'hE3500000, 4'b0011);
    step();
    chk("cmp2_flags", 32'(flags), 32'b0011);
    apply(32'hE3B00000, 4'b0100);
    chk("movs_enables", 32'({regWrite, memWrite, PCSrc}), 32'b100);
    chk("movs_aluctl", 32'(ALUControl), 32'b1101);
    step();
    chk("movs_flags", 32'(flags), 32'b0111);

    // LDR with positive offset
    apply(32'hE5902004, 4'h0);
    chk("ldr_enables", 32'({regWrite, memWrite, PCSrc}), 32'b100);
    chk("ldr_sel", 32'({regSrc, immSrc, ALUSrc, memToReg, ALUControl}), 32'b00_01_1_1_0100);
    // LDR with negative offset uses SUB
    apply(32'hE5102004, 4'h0);
    chk("ldr_sub_aluctl", 32'(ALUControl), 32'b0010);
    // STR
    apply(32'hE5802004, 4'h0);
    chk("str_enables", 32'({regWrite, memWrite, PCSrc}), 32'b010);
    chk("str_sel", 32'({regSrc, memToReg}), 32'b10_0);
    step();
    chk("mem_flags_kept", 32'(flags), 32'b0111);

    // ADDNE with Z=1: suppressed
    apply(32'h12811001, 4'b1000);
    chk("addne_enables", 32'({regWrite, memWrite, PCSrc}), 32'h0);
    // ADDSNE: flag update also suppressed
    apply(32'h12911001, 4'b1000);
    step();
    chk("addsne_flags", 32'(flags), 32'b0111);
    // ADDSEQ passes and loads all four flags
    apply(32'h02911001, 4'b1000);
    chk("addseq_enables", 32'({regWrite, memWrite, PCSrc}), 32'b100);
    step();
    chk("addseq_flags", 32'(flags), 32'b1000);

    // Condition codes with N=1,Z=0,C=0,V=0
    apply(32'hB2811001, 4'h0);
    chk("cond_lt", 32'(regWrite), 32'h1);
    apply(32'hA2811001, 4'h0);
    chk("cond_ge", 32'(regWrite), 32'h0);
    apply(32'h82811001, 4'h0);
    chk("cond_hi", 32'(regWrite), 32'h0);
    apply(32'h92811001, 4'h0);
    chk("cond_ls", 32'(regWrite), 32'h1);
    apply(32'h42811001, 4'h0);
    chk("cond_mi", 32'(regWrite), 32'h1);
    apply(32'hC2811001, 4'h0);
    chk("cond_gt", 32'(regWrite), 32'h0);
    apply(32'hD2811001, 4'h0);
    chk("cond_le", 32'(regWrite), 32'h1);

    // Cond 1111 never executes
    apply(32'hF2811001, 4'h0);
    chk("nv_dp", 32'({regWrite, memWrite, PCSrc}), 32'h0);
    apply(32'hF5802004, 4'h0);
    chk("nv_str", 32'({regWrite, memWrite, PCSrc}), 32'h0);
    apply(32'hFA000002, 4'h0);
    chk("nv_br", 32'({regWrite, memWrite, PCSrc}), 32'h0);

    // ADD PC,R0,#0
    apply(32'hE280F000, 4'h0);
    chk("addpc_enables", 32'({regWrite, memWrite, PCSrc}), 32'b101);
    // CMP with Rd=15 writes no register, so no PC load
    apply(32'hE350F000, 4'h0);
    chk("cmp_rd15", 32'({regWrite, memWrite, PCSrc}), 32'h0);
    // op=11 is a NOP
    apply(32'hEC000000, 4'hF);
    chk("op11_enables", 32'({regWrite, memWrite, PCSrc}), 32'h0);
    chk("op11_sel", 32'({regSrc, immSrc, ALUSrc, memToReg, ALUControl}), 32'h0);
    step();
    chk("op11_flags", 32'(flags), 32'b1000);

    // Load flags 1111, then assert reset mid-cycle with an update pending
    apply(32'hE3500000, 4'hF);
    step();
    chk("cmp3_flags", 32'(flags), 32'hF);
    apply(32'hE3500000, 4'b0110);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_flags", 32'(flags), 32'h0);
    apply(32'hE280F000, 4'h0);
    chk("midrst_enables", 32'({regWrite, memWrite, PCSrc}), 32'h0);
    step();
    reset = 1'b1;
    apply(32'hE3500000, 4'b1001);
    chk("post_rst_flags", 32'(flags), 32'h0);
    step();
    chk("post_rst_update", 32'(flags), 32'b1001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_controller.md
# arm_controller

Control unit for the single-cycle ARM-subset core, sitting directly upstream of the datapath. It decodes the 32-bit instruction into the datapath's mux selects, ALU operation and write enables, and it holds the architectural NZCV flags. Every write enable is gated by the instruction's condition field, evaluated against those flags. Decode is combinational. The flags are the block's only state and update on the rising clock edge.

## Interface
Parameters: none.

- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- instr  in  32  current instruction
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction
- regSrc  out  2  bit0: RA1 = R15; bit1: RA2 = Rd (store)
- regWrite  out  1  register-file write enable, condition-gated
- immSrc  out  2  00 DP imm8, 01 mem imm12, 10 branch imm24
- ALUSrc  out  1  1 selects the extended immediate as srcB
- ALUControl  out  4  ALU operation, ARM cmd encoding
- memToReg  out  1  1 selects readData for register writeback
- memWrite  out  1  data-memory write enable, condition-gated
- PCSrc  out  1  1 loads the PC from the result bus, condition-gated
- flags  out  4  registered {N,Z,C,V}, for debug and verification

## Operation
- Field names used below:
  - op = instr[27:26]
  - funct = instr[25:20]
  - cond = instr[31:28]
  - Rd = instr[15:12]
- op=00, data-processing:
  - ALUSrc = funct[5] (I bit); immSrc = 00; regSrc = 00.
  - ALUControl = instr[24:21].
  - FlagW = funct[0] (S bit).
  - regWrite is raised except for TST, TEQ, CMP and CMN (1000-1011).
- op=01, memory:
  - ALUSrc = 1; immSrc = 01; regSrc[0] = 0.
  - ALUControl = 0100 (ADD) when instr[23]=1, 0010 (SUB) when instr[23]=0.
  - Load (funct[0]=1): regWrite = 1, memToReg = 1, regSrc[1] = 0.
  - Store (funct[0]=0): memWrite = 1, regSrc[1] = 1.
  - No flag write.
- op=10, branch:
  - regSrc[0] = 1; ALUSrc = 1; immSrc = 10; ALUControl = 0100.
  - PCSrc = 1.
  - The L bit is ignored, so BL executes as B.
  - No register or flag write.
- op=11: undefined. All enables 0, other outputs 0; executes as a NOP.
- Rd=15 on any instruction that writes a register: PCSrc = 1 and regWrite = 1.
- Condition check, condEx, against the registered flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C&!Z
  - 1001 LS: !C|Z
  - 1010 GE: N==V
  - 1011 LT: N!=V
  - 1100 GT: !Z&(N==V)
  - 1101 LE: Z|(N!=V)
  - 1110 AL: 1
  - 1111: never
- Gating: regWrite, memWrite, PCSrc and the flag update are ANDed with condEx. Mux selects and ALUControl are not gated.
- Flag update on a clocked edge, when FlagW & condEx:
  - N and Z are always loaded from ALUFlags.
  - C and V are loaded only for arithmetic cmds ADD, ADC, SUB, SBC, RSB, RSC, CMP and CMN. Logical ops (AND, EOR, ORR, BIC, MOV, MVN, TST, TEQ) preserve C and V.

## Timing
- Reset low:
  - flags = 0000, asynchronously.
  - regWrite, memWrite and PCSrc are forced to 0 for as long as reset is low.
  - Other outputs follow decode.
- Reset release: the first rising edge with reset high evaluates normally.
- Decode-to-output latency: zero cycles (combinational).
- Flag update latency: one edge. The condition of instruction k+1 sees the flags written by instruction k.
- A flag-setting conditional instruction evaluates its condition against the old flags, then may update them on the same edge.
- Reset asserted mid-cycle: flags clear immediately and the pending flag update is discarded.

## Test plan
- Reset low with instr=0xE0800001 (ADD R0,R0,R1) -> flags=0000, regWrite=0; after release regWrite=1, ALUSrc=0, ALUControl=0100.
- CMP R0,#0 (0xE3500000) with ALUFlags=0110 -> regWrite=0; after the edge flags=0110. Then BEQ 0x0A000002 -> PCSrc=1, regSrc[0]=1, immSrc=10.
- MOVS R0,#0 (0xE3B00000) after flags=0011, ALUFlags=0100 -> flags become 0111; C and V are preserved.
- LDR R2,[R0,#4] (0xE5902004) -> regWrite=1, memToReg=1, ALUSrc=1, immSrc=01, ALUControl=0100, memWrite=0. STR (0xE5802004) -> memWrite=1, regSrc=10, regWrite=0.
- ADDNE R1,R1,#1 (0x12811001) with flags Z=1 -> regWrite=0, PCSrc=0, flags unchanged. Cond=1111 on any op -> all enables 0.
- ADD PC,R0,#0 (0xE280F000) -> PCSrc=1, regWrite=1. op=11 (0xEC000000) -> all enables 0.
